// File: rtl/sap_1_pkg.sv
// -----------------------------------------------------------------------------
// sap_1_pkg
// Shared definitions for the SAP-1 controller/sequencer:
//   - opcode constants for the five recognised instructions
//   - one-hot T-state encoding, with the all-zero pattern reserved for HALT
//   - bit positions of the 12-bit control word
//   - the control word with every line at its inactive level
// Control word order, MSB first:
//   Cp Ep LmN CeN LiN EiN LaN Ea Su Eu LbN LoN
// -----------------------------------------------------------------------------
package sap_1_pkg;

  // Instruction opcodes (upper nibble of the IR)
  localparam logic [3:0] OP_LDA = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  // One-hot ring states; HALT is the only state with no bit set,
  // so the T output naturally reads 000000 while halted.
  typedef enum logic [5:0] {
    ST_HALT = 6'b000000,
    ST_T1   = 6'b000001,
    ST_T2   = 6'b000010,
    ST_T3   = 6'b000100,
    ST_T4   = 6'b001000,
    ST_T5   = 6'b010000,
    ST_T6   = 6'b100000
  } t_state_e;

  // Control word layout
  localparam int CW_W   = 12;
  localparam int CW_CP  = 11;
  localparam int CW_EP  = 10;
  localparam int CW_LMN = 9;
  localparam int CW_CEN = 8;
  localparam int CW_LIN = 7;
  localparam int CW_EIN = 6;
  localparam int CW_LAN = 5;
  localparam int CW_EA  = 4;
  localparam int CW_SU  = 3;
  localparam int CW_EU  = 2;
  localparam int CW_LBN = 1;
  localparam int CW_LON = 0;

  // Every active-low line high, every active-high line low
  localparam logic [CW_W-1:0] CW_INACTIVE = 12'b0011_1110_0011;

endpackage

// File: rtl/sap_1_ring_counter.sv
// -----------------------------------------------------------------------------
// sap_1_ring_counter
// Six-state one-hot ring counter (T1..T6) with a terminal HALT state.
// All state changes happen on the falling edge of ClkN so that the decoded
// control word has half a cycle to settle before the datapath's rising edge.
// Ports:
//   ClkN       in   system clock, state advances on the falling edge
//   ClrN       in   asynchronous active-low reset, forces T1
//   halt       in   HLT decoded; on the edge ending T4 enter HALT
//   early_wrap in   on the edge ending T4 return to T1 instead of T5
//   T          out  one-hot state, T[0]=T1; 000000 while halted
//   halted     out  high while in HALT
// -----------------------------------------------------------------------------
module sap_1_ring_counter
  import sap_1_pkg::*;
(
  input  logic       ClkN,
  input  logic       ClrN,
  input  logic       halt,
  input  logic       early_wrap,
  output logic [5:0] T,
  output logic       halted
);

  t_state_e state;
  t_state_e state_nxt;

  // State register: reset wins asynchronously, otherwise step on the falling edge
  always_ff @(negedge ClkN or negedge ClrN) begin
    if (!ClrN) begin
      state <= ST_T1;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: T4 is the only branching point; HALT is absorbing
  // and can only be left through ClrN.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_T1:   state_nxt = ST_T2;
      ST_T2:   state_nxt = ST_T3;
      ST_T3:   state_nxt = ST_T4;
      ST_T4: begin
        if (halt) begin
          state_nxt = ST_HALT;
        end else if (early_wrap) begin
          state_nxt = ST_T1;
        end else begin
          state_nxt = ST_T5;
        end
      end
      ST_T5:   state_nxt = ST_T6;
      ST_T6:   state_nxt = ST_T1;
      ST_HALT: state_nxt = ST_HALT;
      default: state_nxt = ST_T1;
    endcase
  end

  assign T      = state;
  assign halted = (state == ST_HALT);

endmodule

// File: rtl/sap_1_controller_sequencer.sv
// -----------------------------------------------------------------------------
// sap_1_controller_sequencer
// Control unit of the SAP-1 datapath: a ring counter plus a decoder that turns
// the current T-state and the IR opcode into the 12-bit control word.
// Parameters:
//   SKIP_IDLE  when 1, OUT and unknown opcodes finish after T4
//   OPW        opcode width
// Ports:
//   ClkN    in   system clock, state changes on the falling edge
//   ClrN    in   asynchronous active-low reset
//   Opcode  in   IR upper nibble, only looked at in T4..T6
//   Cp, Ep  out  PC count / output enable (active high)
//   LmN     out  MAR load (active low)
//   CeN     out  RAM output enable (active low)
//   LiN     out  IR load (active low)
//   EiN     out  IR address-nibble output enable (active low)
//   LaN     out  accumulator load (active low)
//   Ea      out  accumulator output enable (active high)
//   Su, Eu  out  ALU subtract select / output enable (active high)
//   LbN     out  B register load (active low)
//   LoN     out  output register load (active low)
//   Hlt     out  high once HLT has executed
//   T       out  one-hot T-state (debug), 000000 while halted
// -----------------------------------------------------------------------------
module sap_1_controller_sequencer
  import sap_1_pkg::*;
#(
  parameter bit SKIP_IDLE = 1'b0,
  parameter int OPW       = 4
) (
  input  logic           ClkN,
  input  logic           ClrN,
  input  logic [OPW-1:0] Opcode,
  output logic           Cp,
  output logic           Ep,
  output logic           LmN,
  output logic           CeN,
  output logic           LiN,
  output logic           EiN,
  output logic           LaN,
  output logic           Ea,
  output logic           Su,
  output logic           Eu,
  output logic           LbN,
  output logic           LoN,
  output logic           Hlt,
  output logic [5:0]     T
);

  logic [5:0]      t_state;
  logic            halted;
  logic            is_lda;
  logic            is_add;
  logic            is_sub;
  logic            is_out;
  logic            is_hlt;
  logic            mem_ref;
  logic            early_wrap;
  logic [CW_W-1:0] cw_dec;
  logic [CW_W-1:0] cw;

  assign is_lda  = (Opcode == OPW'(OP_LDA));
  assign is_add  = (Opcode == OPW'(OP_ADD));
  assign is_sub  = (Opcode == OPW'(OP_SUB));
  assign is_out  = (Opcode == OPW'(OP_OUT));
  assign is_hlt  = (Opcode == OPW'(OP_HLT));

  // LDA/ADD/SUB need a memory operand and therefore all six states
  assign mem_ref    = is_lda | is_add | is_sub;
  assign early_wrap = SKIP_IDLE && !mem_ref;

  sap_1_ring_counter u_ring (
    .ClkN       (ClkN),
    .ClrN       (ClrN),
    .halt       (is_hlt),
    .early_wrap (early_wrap),
    .T          (t_state),
    .halted     (halted)
  );

  // Decoder: start from all-inactive and switch on only the lines each
  // state needs. Opcode is consulted only in T4..T6, so IR contents during
  // fetch cannot leak onto the control lines. HALT falls to the default.
  always_comb begin
    cw_dec = CW_INACTIVE;
    case (t_state)
      ST_T1: begin
        cw_dec[CW_EP]  = 1'b1;
        cw_dec[CW_LMN] = 1'b0;
      end
      ST_T2: begin
        cw_dec[CW_CP]  = 1'b1;
      end
      ST_T3: begin
        cw_dec[CW_CEN] = 1'b0;
        cw_dec[CW_LIN] = 1'b0;
      end
      ST_T4: begin
        if (mem_ref) begin
          cw_dec[CW_EIN] = 1'b0;
          cw_dec[CW_LMN] = 1'b0;
        end else if (is_out) begin
          cw_dec[CW_EA]  = 1'b1;
          cw_dec[CW_LON] = 1'b0;
        end
      end
      ST_T5: begin
        if (mem_ref) begin
          cw_dec[CW_CEN] = 1'b0;
          if (is_lda) begin
            cw_dec[CW_LAN] = 1'b0;
          end else begin
            cw_dec[CW_LBN] = 1'b0;
          end
        end
      end
      ST_T6: begin
        if (is_add || is_sub) begin
          cw_dec[CW_EU]  = 1'b1;
          cw_dec[CW_LAN] = 1'b0;
          cw_dec[CW_SU]  = is_sub;
        end
      end
      default: begin
        cw_dec = CW_INACTIVE;
      end
    endcase
  end

  // The counter already sits in T1 during reset, so the T1 word would
  // otherwise drive Ep/LmN; gating on ClrN keeps every line quiet the
  // moment ClrN falls and releases the T1 word as soon as it rises.
  assign cw  = ClrN ? cw_dec : CW_INACTIVE;

  assign Cp  = cw[CW_CP];
  assign Ep  = cw[CW_EP];
  assign LmN = cw[CW_LMN];
  assign CeN = cw[CW_CEN];
  assign LiN = cw[CW_LIN];
  assign EiN = cw[CW_EIN];
  assign LaN = cw[CW_LAN];
  assign Ea  = cw[CW_EA];
  assign Su  = cw[CW_SU];
  assign Eu  = cw[CW_EU];
  assign LbN = cw[CW_LBN];
  assign LoN = cw[CW_LON];
  assign Hlt = halted;
  assign T   = t_state;

endmodule

// File: tb/tb_sap_1_controller_sequencer.sv
// -----------------------------------------------------------------------------
// tb_sap_1_controller_sequencer
// Self-checking bench for sap_1_controller_sequencer. Two instances share
// clock, reset and opcode: dut0 with SKIP_IDLE=0 and dut1 with SKIP_IDLE=1.
// Control words are compared as a 12-bit vector ordered
//   Cp Ep LmN CeN LiN EiN LaN Ea Su Eu LbN LoN
// -----------------------------------------------------------------------------
module tb_sap_1_controller_sequencer;

  // Expected control words, worked out by hand from the instruction table
  localparam logic [11:0] W_IDLE = 12'b0011_1110_0011;
  localparam logic [11:0] W_T1   = 12'b0101_1110_0011;
  localparam logic [11:0] W_T2   = 12'b1011_1110_0011;
  localparam logic [11:0] W_T3   = 12'b0010_0110_0011;
  localparam logic [11:0] W_MAR4 = 12'b0001_1010_0011;
  localparam logic [11:0] W_LDA5 = 12'b0010_1100_0011;
  localparam logic [11:0] W_ADD5 = 12'b0010_1110_0001;
  localparam logic [11:0] W_ADD6 = 12'b0011_1100_0111;
  localparam logic [11:0] W_SUB6 = 12'b0011_1100_1111;
  localparam logic [11:0] W_OUT4 = 12'b0011_1111_0010;

  localparam logic [5:0] S_HALT = 6'b000000;
  localparam logic [5:0] S_T1   = 6'b000001;
  localparam logic [5:0] S_T2   = 6'b000010;
  localparam logic [5:0] S_T3   = 6'b000100;
  localparam logic [5:0] S_T4   = 6'b001000;
  localparam logic [5:0] S_T5   = 6'b010000;
  localparam logic [5:0] S_T6   = 6'b100000;

  // Six cycles following T1 for a full-length and a shortened instruction
  localparam logic [5:0]  FULL_T [6]  = '{S_T2, S_T3, S_T4, S_T5, S_T6, S_T1};
  localparam logic [5:0]  SHORT_T [6] = '{S_T2, S_T3, S_T4, S_T1, S_T2, S_T3};
  localparam logic [11:0] OUT0_CW [6] = '{W_T2, W_T3, W_OUT4, W_IDLE, W_IDLE, W_T1};
  localparam logic [11:0] OUT1_CW [6] = '{W_T2, W_T3, W_OUT4, W_T1, W_T2, W_T3};
  localparam logic [11:0] NOP1_CW [6] = '{W_T2, W_T3, W_IDLE, W_T1, W_T2, W_T3};
  localparam logic [11:0] LDA_CW [6]  = '{W_T2, W_T3, W_MAR4, W_LDA5, W_IDLE, W_T1};

  typedef struct {
    logic [3:0]  op;
    logic [5:0]  t;
    logic [11:0] cw;
    logic        hlt;
  } vec_t;

  logic       ClkN;
  logic       ClrN;
  logic [3:0] Opcode;

  logic cp0, ep0, lmn0, cen0, lin0, ein0, lan0, ea0, su0, eu0, lbn0, lon0, hlt0;
  logic cp1, ep1, lmn1, cen1, lin1, ein1, lan1, ea1, su1, eu1, lbn1, lon1, hlt1;
  logic [5:0]  t0;
  logic [5:0]  t1;
  logic [11:0] cw0;
  logic [11:0] cw1;

  int   n_vec;
  int   n_miss;
  vec_t vecs[$];

  assign cw0 = {cp0, ep0, lmn0, cen0, lin0, ein0, lan0, ea0, su0, eu0, lbn0, lon0};
  assign cw1 = {cp1, ep1, lmn1, cen1, lin1, ein1, lan1, ea1, su1, eu1, lbn1, lon1};

  sap_1_controller_sequencer #(.SKIP_IDLE(1'b0), .OPW(4)) dut0 (
    .ClkN(ClkN), .ClrN(ClrN), .Opcode(Opcode),
    .Cp(cp0), .Ep(ep0), .LmN(lmn0), .CeN(cen0), .LiN(lin0), .EiN(ein0),
    .LaN(lan0), .Ea(ea0), .Su(su0), .Eu(eu0), .LbN(lbn0), .LoN(lon0),
    .Hlt(hlt0), .T(t0)
  );

  sap_1_controller_sequencer #(.SKIP_IDLE(1'b1), .OPW(4)) dut1 (
    .ClkN(ClkN), .ClrN(ClrN), .Opcode(Opcode),
    .Cp(cp1), .Ep(ep1), .LmN(lmn1), .CeN(cen1), .LiN(lin1), .EiN(ein1),
    .LaN(lan1), .Ea(ea1), .Su(su1), .Eu(eu1), .LbN(lbn1), .LoN(lon1),
    .Hlt(hlt1), .T(t1)
  );

  // Clock starts low so falling edges land on multiples of 10
  initial begin
    ClkN = 1'b0;
    forever #5 ClkN = ~ClkN;
  end

  // Guard against a run that never reaches its summary
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: run exceeded its time budget");
    $fatal(1, "[TB] watchdog expired");
  end

  // Compare one instance's T, control word and Hlt against expectations
  task automatic checkOutput(input string name,
                             input logic [5:0] t_act, input logic [5:0] t_exp,
                             input logic [11:0] cw_act, input logic [11:0] cw_exp,
                             input logic hlt_act, input logic hlt_exp);
    n_vec++;
    if (t_act !== t_exp || cw_act !== cw_exp || hlt_act !== hlt_exp) begin
      n_miss++;
      $display("[TB] FAIL %s: got T=%b cw=%b Hlt=%b, expected T=%b cw=%b Hlt=%b",
               name, t_act, cw_act, hlt_act, t_exp, cw_exp, hlt_exp);
    end
  endtask

  // Move into the next clock cycle, drive the opcode, wait until mid-cycle
  task automatic applyStimulus(input logic [3:0] op);
    @(negedge ClkN);
    #1;
    Opcode = op;
    @(posedge ClkN);
  endtask

  // Pulse ClrN between edges; outputs must go quiet at once and the T1
  // word must appear as soon as ClrN is released
  task automatic pulse_reset;
    #1 ClrN = 1'b0;
    #1;
    checkOutput("reset_async0", t0, S_T1, cw0, W_IDLE, hlt0, 1'b0);
    checkOutput("reset_async1", t1, S_T1, cw1, W_IDLE, hlt1, 1'b0);
    #1 ClrN = 1'b1;
    #1;
    checkOutput("reset_release0", t0, S_T1, cw0, W_T1, hlt0, 1'b0);
    checkOutput("reset_release1", t1, S_T1, cw1, W_T1, hlt1, 1'b0);
  endtask

  // At most one bus driver per state, and T one-hot
  task automatic check_bus(input string name, input logic [11:0] cw, input logic [5:0] t);
    int drivers;
    drivers = int'(cw[10]) + int'(!cw[8]) + int'(!cw[6]) + int'(cw[4]) + int'(cw[2]);
    n_vec++;
    if (drivers > 1 || !$onehot(t)) begin
      n_miss++;
      $display("[TB] FAIL %s: got %0d bus drivers with T=%b, expected at most 1 driver and one-hot T",
               name, drivers, t);
    end
  endtask

  task automatic add_vec(input logic [3:0] op, input logic [5:0] t,
                         input logic [11:0] cw, input logic hlt);
    vec_t v;
    v.op = op; v.t = t; v.cw = cw; v.hlt = hlt;
    vecs.push_back(v);
  endtask

  initial begin
    n_vec  = 0;
    n_miss = 0;
    ClrN   = 1'b0;
    Opcode = 4'h0;

    // LDA, with junk opcodes during the following fetch
    add_vec(4'h0, S_T2, W_T2,   1'b0);
    add_vec(4'h0, S_T3, W_T3,   1'b0);
    add_vec(4'h0, S_T4, W_MAR4, 1'b0);
    add_vec(4'h0, S_T5, W_LDA5, 1'b0);
    add_vec(4'h0, S_T6, W_IDLE, 1'b0);
    add_vec(4'hF, S_T1, W_T1,   1'b0);
    add_vec(4'hF, S_T2, W_T2,   1'b0);
    add_vec(4'hE, S_T3, W_T3,   1'b0);
    // SUB
    add_vec(4'h2, S_T4, W_MAR4, 1'b0);
    add_vec(4'h2, S_T5, W_ADD5, 1'b0);
    add_vec(4'h2, S_T6, W_SUB6, 1'b0);
    // ADD
    add_vec(4'h1, S_T1, W_T1,   1'b0);
    add_vec(4'h1, S_T2, W_T2,   1'b0);
    add_vec(4'h1, S_T3, W_T3,   1'b0);
    add_vec(4'h1, S_T4, W_MAR4, 1'b0);
    add_vec(4'h1, S_T5, W_ADD5, 1'b0);
    add_vec(4'h1, S_T6, W_ADD6, 1'b0);
    // OUT, full length on dut0
    add_vec(4'hE, S_T1, W_T1,   1'b0);
    add_vec(4'hE, S_T2, W_T2,   1'b0);
    add_vec(4'hE, S_T3, W_T3,   1'b0);
    add_vec(4'hE, S_T4, W_OUT4, 1'b0);
    add_vec(4'hE, S_T5, W_IDLE, 1'b0);
    add_vec(4'hE, S_T6, W_IDLE, 1'b0);
    // Undefined opcode behaves as NOP
    add_vec(4'h7, S_T1, W_T1,   1'b0);
    add_vec(4'h7, S_T2, W_T2,   1'b0);
    add_vec(4'h7, S_T3, W_T3,   1'b0);
    add_vec(4'h7, S_T4, W_IDLE, 1'b0);
    add_vec(4'h7, S_T5, W_IDLE, 1'b0);
    add_vec(4'h7, S_T6, W_IDLE, 1'b0);
    // HLT: quiet T4, then frozen in HALT regardless of opcode
    add_vec(4'hF, S_T1, W_T1,   1'b0);
    add_vec(4'hF, S_T2, W_T2,   1'b0);
    add_vec(4'hF, S_T3, W_T3,   1'b0);
    add_vec(4'hF, S_T4, W_IDLE, 1'b0);
    add_vec(4'hF, S_HALT, W_IDLE, 1'b1);
    add_vec(4'h0, S_HALT, W_IDLE, 1'b1);
    add_vec(4'h1, S_HALT, W_IDLE, 1'b1);

    // Reset held for 15 time units
    #12;
    checkOutput("in_reset0", t0, S_T1, cw0, W_IDLE, hlt0, 1'b0);
    checkOutput("in_reset1", t1, S_T1, cw1, W_IDLE, hlt1, 1'b0);
    #3 ClrN = 1'b1;
    #1;
    checkOutput("after_reset0", t0, S_T1, cw0, W_T1, hlt0, 1'b0);
    checkOutput("after_reset1", t1, S_T1, cw1, W_T1, hlt1, 1'b0);

    $display("[TB] table of %0d vectors on SKIP_IDLE=0 instance", vecs.size());
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].op);
      checkOutput($sformatf("vec%0d", i), t0, vecs[i].t, cw0, vecs[i].cw, hlt0, vecs[i].hlt);
    end

    // Ten more clocks in HALT with the opcode wandering
    for (int i = 0; i < 10; i++) begin
      applyStimulus(4'(i));
      checkOutput($sformatf("halt_hold%0d", i), t0, S_HALT, cw0, W_IDLE, hlt0, 1'b1);
    end
    pulse_reset();

    // OUT: six cycles without SKIP_IDLE, four with it
    for (int i = 0; i < 6; i++) begin
      applyStimulus(4'hE);
      checkOutput($sformatf("out_full%0d", i), t0, FULL_T[i], cw0, OUT0_CW[i], hlt0, 1'b0);
      checkOutput($sformatf("out_skip%0d", i), t1, SHORT_T[i], cw1, OUT1_CW[i], hlt1, 1'b0);
    end

    // Undefined opcode also wraps early with SKIP_IDLE
    pulse_reset();
    for (int i = 0; i < 6; i++) begin
      applyStimulus(4'h9);
      checkOutput($sformatf("nop_skip%0d", i), t1, SHORT_T[i], cw1, NOP1_CW[i], hlt1, 1'b0);
    end

    // LDA keeps all six states even with SKIP_IDLE
    pulse_reset();
    for (int i = 0; i < 6; i++) begin
      applyStimulus(4'h0);
      checkOutput($sformatf("lda_skip%0d", i), t1, FULL_T[i], cw1, LDA_CW[i], hlt1, 1'b0);
    end

    // Reset in the middle of ADD's T5
    pulse_reset();
    applyStimulus(4'h1);
    applyStimulus(4'h1);
    applyStimulus(4'h1);
    applyStimulus(4'h1);
    checkOutput("add_mid_t5", t0, S_T5, cw0, W_ADD5, hlt0, 1'b0);
    pulse_reset();

    // Random opcodes (HLT excluded so the ring keeps moving)
    for (int i = 0; i < 200; i++) begin
      applyStimulus(4'($urandom_range(0, 14)));
      check_bus($sformatf("bus0_%0d", i), cw0, t0);
      check_bus($sformatf("bus1_%0d", i), cw1, t1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/sap_1_controller_sequencer.md
Name: sap_1_controller_sequencer

Overview:
Control unit of the SAP-1 datapath. Sits directly upstream of sap_1_program_counter and drives its Cp/Ep, plus every other load/enable line on the W bus. It contains a 6-state ring counter (T1..T6) and a decoder. The decoder turns the current T-state and the IR opcode into the 12-bit control word, and it halts the machine on HLT.

Parameters:
SKIP_IDLE, 0, when 1, OUT and undefined opcodes return to T1 after T4 instead of idling through T5/T6.
OPW, 4, opcode width (upper nibble of IR).

Ports:
ClkN  input  1  system clock; all state changes on the falling edge.
ClrN  input  1  asynchronous active-low reset.
Opcode  input  OPW  instruction-register upper nibble; valid from T4 onward.
Cp  output  1  PC count enable (active high).
Ep  output  1  PC output enable (active high).
LmN  output  1  MAR load (active low).
CeN  output  1  RAM output enable (active low).
LiN  output  1  IR load (active low).
EiN  output  1  IR address-nibble output enable (active low).
LaN  output  1  accumulator load (active low).
Ea  output  1  accumulator output enable (active high).
Su  output  1  ALU subtract select (active high).
Eu  output  1  ALU output enable (active high).
LbN  output  1  B register load (active low).
LoN  output  1  output register load (active low).
Hlt  output  1  high once HLT has executed.
T  output  6  one-hot T-state, T[0]=T1 (debug).

Behaviour:
- Reset (ClrN=0, asynchronous): state forced to T1, T=6'b000001, Hlt=0. All control outputs are held inactive (Cp=Ep=Ea=Su=Eu=0, all *N=1) for as long as ClrN=0. After ClrN rises, the T1 control word drives immediately.
- Ring counter: advances T1→T2→…→T6→T1 on each falling ClkN edge. Exactly one T bit is high outside reset.
- Control outputs are combinational from the state and Opcode. They must be stable before the following rising edge, which is when the datapath registers load.
- Fetch, opcode-independent:
  - T1: Ep=1, LmN=0.
  - T2: Cp=1.
  - T3: CeN=0, LiN=0.
- Execute (inactive unless listed):
  - LDA 4'h0: T4 EiN=0, LmN=0. T5 CeN=0, LaN=0. T6 none.
  - ADD 4'h1: T4 EiN=0, LmN=0. T5 CeN=0, LbN=0. T6 Eu=1, LaN=0.
  - SUB 4'h2: same as ADD, plus Su=1 in T6.
  - OUT 4'hE: T4 Ea=1, LoN=0. T5 and T6 none.
  - HLT 4'hF: T4 none. On the falling edge that ends T4, enter HALT.
  - Other opcodes: NOP, with T4–T6 inactive.
- HALT state:
  - All controls inactive, Hlt=1, T=6'b000000.
  - Counter frozen. Only ClrN exits HALT.
  - Opcode changes are ignored.
- SKIP_IDLE=1: for OUT and NOP, the falling edge ending T4 goes to T1. LDA, ADD and SUB still use all six states.
- Opcode is sampled only in T4..T6. Changes during T1..T3 have no effect on the outputs.
- Reset mid-instruction (any state, including HALT): returns asynchronously to T1 with outputs inactive. No partial control pulse is allowed after ClrN falls.
- At most one bus driver is active in any state (Ep, CeN=0, EiN=0, Ea, Eu). This is an assertion for verification.

Decomposition:
- sap_1_pkg holds:
  - opcode constants (LDA/ADD/SUB/OUT/HLT)
  - T-state one-hot encoding and HALT
  - control-word bit indices
  - the inactive control-word constant (12'b0011_1110_0011, ordered Cp Ep LmN CeN LiN EiN LaN Ea Su Eu LbN LoN).
- Sub-module sap_1_ring_counter: one-hot 6-state counter with inputs ClkN, ClrN, halt and early_wrap, and outputs T and halted. The top level is the decoder plus the gating logic.

Test Plan:
1. ClrN=0 for 15 ns, then released. Expect all controls inactive and T=000001 during reset. After release, Ep=1 and LmN=0. The next five falling edges step T through 000010…100000, then back to 000001.
2. Opcode=4'h0 (LDA). Expect T4 EiN=LmN=0, T5 CeN=LaN=0, T6 all inactive. The fetch words in T1–T3 match the Behaviour list exactly.
3. Opcode=4'h2 (SUB). Expect T6 Su=1, Eu=1, LaN=0. With Opcode=4'h1 (ADD), T6 has the same word but Su=0.
4. Opcode=4'hF (HLT). Expect Hlt=1 and T=000000 after the T4 falling edge. After 10 more clocks with Opcode toggled, still halted. ClrN pulse → T=000001, Hlt=0.
5. SKIP_IDLE=1 with Opcode=4'hE. Expect T4 Ea=1, LoN=0, then the next state is T1 (a 4-cycle instruction). With SKIP_IDLE=0, the instruction takes 6 cycles.
6. ClrN asserted mid-T5 of ADD. Expect LbN to return to 1 within the same ns step and T=000001. The bus-driver one-hot assertion never fires across 200 random opcodes.
